// File: rtl/uart_send.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// Frames leave LSB-first; a queued byte follows the previous stop bit with no idle gap.
module uart_send #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       send_en,
   input  logic [7:0] send_din,
   output logic       send_dout,
   output logic       send_busy,
   output logic       send_full,
   output logic       send_done,
   output logic       send_ovf
);

   localparam int BPS_CNT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(BPS_CNT - 1);
   localparam logic [PTR_W:0]   FIFO_MAX = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_baud;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_dout;
   logic             r_done;
   logic             r_ovf;
   logic             r_full;
   logic [PTR_W:0]   r_cnt;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [7:0]       r_mem [FIFO_DEPTH];

   logic             w_wr;
   logic             w_pop;
   logic             w_cnt_nz;
   logic             w_baud_end;
   logic [PTR_W:0]   w_cnt_nxt;
   logic [7:0]       w_head;

   assign w_cnt_nz   = (r_cnt != '0);
   assign w_baud_end = (r_baud == BAUD_MAX);
   // A write seen while full is dropped even if a pop frees a slot this cycle.
   assign w_wr       = send_en & ~r_full;
   assign w_pop      = w_cnt_nz & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_end));
   assign w_cnt_nxt  = r_cnt + (PTR_W + 1)'(w_wr) - (PTR_W + 1)'(w_pop);
   assign w_head     = r_mem[r_rd_ptr];

   always_ff @(posedge sys_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= send_din;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_full <= (w_cnt_nxt == FIFO_MAX);
         r_ovf  <= send_en & r_full;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_pop) begin
         r_shift <= w_head;
      end else if (w_baud_end && ((r_state == S_START) || (r_state == S_DATA))) begin
         r_shift <= {1'b0, r_shift[7:1]};
      end
   end

   // Line level is always a flop output so the TX pin never glitches.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_dout  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_dout <= 1'b1;
               r_baud <= '0;
               if (w_cnt_nz) begin
                  r_dout  <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= 3'd0;
                  r_dout  <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_dout  <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit  <= r_bit + 3'd1;
                     r_dout <= r_shift[0];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  r_done <= 1'b1;
                  if (w_cnt_nz) begin
                     r_dout  <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_dout  <= 1'b1;
               r_baud  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign send_dout = r_dout;
   assign send_busy = (r_state != S_IDLE);
   assign send_full = r_full;
   assign send_done = r_done;
   assign send_ovf  = r_ovf;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: a line decoder acts as the loopback receiver and feeds
// a frame queue that each scenario compares against its expected-byte queue.
module tb_uart_send;

   localparam int CLK_FREQ   = 50_000_000;
   localparam int BAUD_RATE  = 5_000_000;
   localparam int FIFO_DEPTH = 4;
   localparam int BPS        = 10;
   localparam int FRAME      = 10 * BPS;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       send_en   = 1'b0;
   logic [7:0] send_din  = 8'h00;
   logic       send_dout;
   logic       send_busy;
   logic       send_full;
   logic       send_done;
   logic       send_ovf;

   uart_send #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .send_en  (send_en),
      .send_din (send_din),
      .send_dout(send_dout),
      .send_busy(send_busy),
      .send_full(send_full),
      .send_done(send_done),
      .send_ovf (send_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0] data;
      logic       start_b;
      logic       stop_b;
      bit         shape_ok;
      bit         busy_ok;
      bit         done_ok;
      int         t0;
   } frame_t;

   int         cyc      = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         ovf_cnt  = 0;
   int         done_cnt = 0;
   logic [7:0] exp_q[$];
   frame_t     rx_q[$];

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (send_ovf === 1'b1) ovf_cnt <= ovf_cnt + 1;
      if (send_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Line decoder: sees a start bit, records every cycle of the frame, then the done pulse.
   initial begin : mon
      bit         carry;
      bit         abort;
      logic [9:0] lv;
      frame_t     f;
      carry = 1'b0;
      forever begin
         if (!carry) @(negedge sys_clk);
         carry = 1'b0;
         if (sys_rst_n === 1'b1 && send_dout === 1'b0) begin
            f.t0 = cyc; f.shape_ok = 1'b1; f.busy_ok = 1'b1; f.done_ok = 1'b1;
            abort = 1'b0; lv = '0;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge sys_clk);
               if (sys_rst_n !== 1'b1) abort = 1'b1;
               if (i % BPS == 0) lv[i / BPS] = send_dout;
               else if (send_dout !== lv[i / BPS]) f.shape_ok = 1'b0;
               if (send_busy !== 1'b1) f.busy_ok = 1'b0;
               if (i > 0 && send_done !== 1'b0) f.done_ok = 1'b0;
            end
            @(negedge sys_clk);
            if (sys_rst_n !== 1'b1) abort = 1'b1;
            if (send_done !== 1'b1) f.done_ok = 1'b0;
            f.start_b = lv[0]; f.data = lv[8:1]; f.stop_b = lv[9];
            if (!abort) rx_q.push_back(f);
            carry = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic write_byte(input logic [7:0] b, input bit accept);
      send_en  = 1'b1;
      send_din = b;
      if (accept) exp_q.push_back(b);
      @(negedge sys_clk);
   endtask

   task automatic wait_frames(input int n, input int tmo, output bit ok);
      int k = 0;
      while (rx_q.size() < n && k < tmo) begin
         @(negedge sys_clk);
         k++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic test_reset;
      int base;
      sys_rst_n = 1'b0; send_en = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_checks++;
      if ({send_dout, send_busy, send_full, send_done, send_ovf} !== 5'b10000)
         $display("FAIL reset_held: outputs %b, required 10000",
                  {send_dout, send_busy, send_full, send_done, send_ovf});
      else n_pass++;
      base = ovf_cnt + done_cnt;
      sys_rst_n = 1'b1;
      repeat (20) @(negedge sys_clk);
      n_checks++;
      if ({send_dout, send_busy, send_full, send_done, send_ovf} !== 5'b10000)
         $display("FAIL reset_release: outputs %b, required 10000",
                  {send_dout, send_busy, send_full, send_done, send_ovf});
      else n_pass++;
      n_checks++;
      if (ovf_cnt + done_cnt - base != 0 || rx_q.size() != 0)
         $display("FAIL reset_quiet: pulses %0d frames %0d, required 0 and 0",
                  ovf_cnt + done_cnt - base, rx_q.size());
      else n_pass++;
   endtask

   task automatic test_single;
      bit ok; int wc; int dbase; frame_t f; logic [7:0] e;
      dbase = done_cnt;
      write_byte(8'hA5, 1'b1);
      send_en = 1'b0;
      wc = cyc;
      wait_frames(1, 200, ok);
      n_checks++;
      if (!ok) $display("FAIL single_timeout: frames %0d, required 1", rx_q.size());
      else n_pass++;
      if (ok) begin
         f = rx_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (f.data !== e) $display("FAIL single_data: got %h, required %h", f.data, e);
         else n_pass++;
         n_checks++;
         if ({f.start_b, f.stop_b, f.shape_ok, f.busy_ok, f.done_ok} !== 5'b01111)
            $display("FAIL single_format: start/stop/shape/busy/done %b, required 01111",
                     {f.start_b, f.stop_b, f.shape_ok, f.busy_ok, f.done_ok});
         else n_pass++;
         n_checks++;
         if (f.t0 !== wc + 1) $display("FAIL single_latency: start at cycle %0d, required %0d", f.t0, wc + 1);
         else n_pass++;
      end
      repeat (5) @(negedge sys_clk);
      n_checks++;
      if ({send_dout, send_busy} !== 2'b10) $display("FAIL single_idle: dout/busy %b, required 10", {send_dout, send_busy});
      else n_pass++;
      n_checks++;
      if (done_cnt - dbase !== 1) $display("FAIL single_done_count: got %0d, required 1", done_cnt - dbase);
      else n_pass++;
   endtask

   task automatic check_run(input string name, input int n);
      bit ok; int prev; frame_t f; logic [7:0] e;
      wait_frames(n, n * FRAME + 100, ok);
      n_checks++;
      if (!ok) $display("FAIL %s_timeout: frames %0d, required %0d", name, rx_q.size(), n);
      else n_pass++;
      prev = 0;
      for (int i = 0; i < n && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         f = rx_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (f.data !== e) $display("FAIL %s_data%0d: got %h, required %h", name, i, f.data, e);
         else n_pass++;
         n_checks++;
         if ({f.start_b, f.stop_b, f.shape_ok, f.busy_ok, f.done_ok} !== 5'b01111)
            $display("FAIL %s_format%0d: start/stop/shape/busy/done %b, required 01111", name, i,
                     {f.start_b, f.stop_b, f.shape_ok, f.busy_ok, f.done_ok});
         else n_pass++;
         if (i > 0) begin
            n_checks++;
            if (f.t0 - prev !== FRAME) $display("FAIL %s_gap%0d: spacing %0d, required %0d", name, i, f.t0 - prev, FRAME);
            else n_pass++;
         end
         prev = f.t0;
      end
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_back_to_back;
      int dbase;
      dbase = done_cnt;
      write_byte(8'h00, 1'b1);
      write_byte(8'hFF, 1'b1);
      write_byte(8'h3C, 1'b1);
      send_en = 1'b0;
      check_run("b2b", 3);
      n_checks++;
      if (done_cnt - dbase !== 3) $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - dbase);
      else n_pass++;
   endtask

   task automatic test_random_burst;
      for (int i = 0; i < 4; i++) write_byte(8'($urandom_range(0, 255)), 1'b1);
      send_en = 1'b0;
      check_run("rand", 4);
   endtask

   task automatic test_overflow;
      int obase;
      obase = ovf_cnt;
      for (int i = 1; i <= 4; i++) write_byte(8'(i), 1'b1);
      n_checks++;
      if (send_full !== 1'b0) $display("FAIL ovf_full_early: full %b after 4 writes, required 0", send_full);
      else n_pass++;
      write_byte(8'h05, 1'b1);
      n_checks++;
      if (send_full !== 1'b1) $display("FAIL ovf_full: full %b after 5 writes, required 1", send_full);
      else n_pass++;
      write_byte(8'h06, 1'b0);
      send_en = 1'b0;
      n_checks++;
      if (send_ovf !== 1'b1) $display("FAIL ovf_pulse: ovf %b after dropped write, required 1", send_ovf);
      else n_pass++;
      @(negedge sys_clk);
      n_checks++;
      if (send_ovf !== 1'b0) $display("FAIL ovf_pulse_width: ovf %b one cycle later, required 0", send_ovf);
      else n_pass++;
      check_run("ovf", 5);
      n_checks++;
      if (ovf_cnt - obase !== 1) $display("FAIL ovf_count: got %0d pulses, required 1", ovf_cnt - obase);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int k; bit bad; int nbefore;
      nbefore = rx_q.size();
      write_byte(8'h55, 1'b0);
      write_byte(8'h11, 1'b0);
      write_byte(8'h22, 1'b0);
      send_en = 1'b0;
      k = 0;
      while (send_dout !== 1'b0 && k < 20) begin
         @(negedge sys_clk);
         k++;
      end
      n_checks++;
      if (send_dout !== 1'b0) $display("FAIL midrst_start: dout %b, required 0", send_dout);
      else n_pass++;
      repeat (45) @(negedge sys_clk);
      #1 sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({send_dout, send_busy, send_full} !== 3'b100)
         $display("FAIL midrst_async: dout/busy/full %b, required 100", {send_dout, send_busy, send_full});
      else n_pass++;
      repeat (3) @(negedge sys_clk);
      #1 sys_rst_n = 1'b1;
      bad = 1'b0;
      repeat (300) begin
         @(negedge sys_clk);
         if (send_dout !== 1'b1 || send_busy !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL midrst_no_frame: line left idle after reset release, required idle");
      else n_pass++;
      n_checks++;
      if (rx_q.size() !== nbefore) $display("FAIL midrst_frames: got %0d frames, required %0d", rx_q.size(), nbefore);
      else n_pass++;
   endtask

   task automatic test_loopback;
      write_byte(8'h3C, 1'b1);
      send_en = 1'b0;
      check_run("loop", 1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random_burst();
      test_overflow();
      test_reset_mid();
      test_loopback();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
